// File: rtl/plic_seq_pkg.sv
// Shared state encoding, PLIC register map offsets and enable-mask helper for the init sequencer.
// Latency: n/a (package).
// Backpressure: n/a.
package plic_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRIO = 2'd1,
        IE   = 2'd2,
        THR  = 2'd3
    } seq_state_e;

    localparam logic [31:0] PRIO_OFS   = 32'h0000_0000;
    localparam logic [31:0] IE_OFS     = 32'h0000_2000;
    localparam logic [31:0] IE_STRIDE  = 32'h0000_0080;
    localparam logic [31:0] THR_OFS    = 32'h0020_0000;
    localparam logic [31:0] THR_STRIDE = 32'h0000_1000;

    // Enable word w: all sources enabled (or none), except the reserved source 0
    // and any bit position past the last real source.
    function automatic logic [31:0] ie_word_mask(input int unsigned w,
                                                 input int unsigned n_source,
                                                 input logic        def_ie);
        logic [31:0] m;
        int unsigned idx;
        m = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            idx  = w * 32 + b;
            m[b] = def_ie && (idx != 0) && (idx <= n_source);
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_intf.sv
// Register-interface bus types shared by the PLIC and anything sitting in front of it.
// Latency: n/a (types only).
// Backpressure: a transfer completes when valid && ready in the same cycle.
package reg_intf;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d32;

endpackage

// File: rtl/plic_seq_addr_gen.sv
// Walks source/target/word counters and produces the address and data of the current config write.
// Latency: addr/wdata are combinational from the counters; counters step one cycle after advance_i.
// Backpressure: counters only move on advance_i, so addr/wdata hold while the write is stalled.
module plic_seq_addr_gen
    import plic_seq_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 128,
    parameter int unsigned N_TARGET   = 60,
    parameter int unsigned MAX_PRIO   = 7,
    parameter int unsigned DEF_PRIO   = 1,
    parameter int unsigned DEF_THRESH = 0,
    parameter logic        DEF_IE     = 1'b1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  seq_state_e  state_i,
    input  logic        advance_i,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        phase_last_o,
    output logic        last_o
);

    localparam int unsigned NW    = (N_SOURCE + 1 + 31) / 32;
    localparam int unsigned PRIOW = $clog2(MAX_PRIO + 1);
    localparam int unsigned SRCW  = (N_SOURCE + 1 > 1) ? $clog2(N_SOURCE + 1) : 1;
    localparam int unsigned TGTW  = (N_TARGET > 1) ? $clog2(N_TARGET) : 1;
    localparam int unsigned WRDW  = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [SRCW-1:0]  LAST_SRC  = SRCW'(N_SOURCE);
    localparam logic [TGTW-1:0]  LAST_TGT  = TGTW'(N_TARGET - 1);
    localparam logic [WRDW-1:0]  LAST_WRD  = WRDW'(NW - 1);
    localparam logic [PRIOW-1:0] PRIO_VAL  = PRIOW'(DEF_PRIO);
    localparam logic [PRIOW-1:0] THR_VAL   = PRIOW'(DEF_THRESH);

    logic [SRCW-1:0] src_q,  src_d;
    logic [TGTW-1:0] tgt_q,  tgt_d;
    logic [WRDW-1:0] word_q, word_d;

    logic src_last, tgt_last, word_last;

    assign src_last  = (src_q == LAST_SRC);
    assign tgt_last  = (tgt_q == LAST_TGT);
    assign word_last = (word_q == LAST_WRD);

    // Next counter values: parked at the first write while idle, stepped on each accepted write.
    always_comb begin
        src_d  = src_q;
        tgt_d  = tgt_q;
        word_d = word_q;
        case (state_i)
            IDLE: begin
                src_d  = SRCW'(1);
                tgt_d  = '0;
                word_d = '0;
            end
            PRIO: begin
                if (advance_i && !src_last) src_d = src_q + SRCW'(1);
            end
            IE: begin
                if (advance_i) begin
                    if (word_last) begin
                        word_d = '0;
                        tgt_d  = tgt_last ? '0 : tgt_q + TGTW'(1);
                    end else begin
                        word_d = word_q + WRDW'(1);
                    end
                end
            end
            THR: begin
                if (advance_i) tgt_d = tgt_last ? '0 : tgt_q + TGTW'(1);
            end
            default: ;
        endcase
    end

    // Counter registers; reset lands on the first write of a sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q  <= SRCW'(1);
            tgt_q  <= '0;
            word_q <= '0;
        end else begin
            src_q  <= src_d;
            tgt_q  <= tgt_d;
            word_q <= word_d;
        end
    end

    // Address, data and end-of-phase flags for the write currently presented.
    always_comb begin
        addr_o       = '0;
        wdata_o      = '0;
        phase_last_o = 1'b0;
        case (state_i)
            PRIO: begin
                addr_o       = BASE_ADDR + PRIO_OFS + (32'(src_q) << 2);
                wdata_o      = 32'(PRIO_VAL);
                phase_last_o = src_last;
            end
            IE: begin
                addr_o       = BASE_ADDR + IE_OFS + IE_STRIDE * 32'(tgt_q) + (32'(word_q) << 2);
                wdata_o      = ie_word_mask(32'(word_q), N_SOURCE, DEF_IE);
                phase_last_o = word_last && tgt_last;
            end
            THR: begin
                addr_o       = BASE_ADDR + THR_OFS + THR_STRIDE * 32'(tgt_q);
                wdata_o      = 32'(THR_VAL);
                phase_last_o = tgt_last;
            end
            default: ;
        endcase
    end

    assign last_o = (state_i == THR) && tgt_last;

endmodule

// File: rtl/plic_init_sequencer.sv
// Boot-time PLIC configurator and arbiter: writes default priorities, enables and thresholds, else passes host traffic.
// Latency: zero-cycle pass-through when idle; sequencer write valid starts the cycle after leaving IDLE.
// Backpressure: each write holds until PLIC ready; host sees ready=0 while a sequence owns the bus.
module plic_init_sequencer
    import plic_seq_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 128,
    parameter int unsigned N_TARGET   = 60,
    parameter int unsigned MAX_PRIO   = 7,
    parameter int unsigned DEF_PRIO   = 1,
    parameter int unsigned DEF_THRESH = 0,
    parameter logic        DEF_IE     = 1'b1,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic        AUTO_START = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    input  reg_intf::reg_intf_req_a32_d32 req_i,
    output reg_intf::reg_intf_resp_d32    resp_o,
    output reg_intf::reg_intf_req_a32_d32 req_o,
    input  reg_intf::reg_intf_resp_d32    resp_i
);

    seq_state_e  state_q;
    logic        pending_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] gen_addr;
    logic [31:0] gen_wdata;
    logic        phase_last;
    logic        seq_last;
    logic        seq_hs;

    // The sequencer always drives valid outside IDLE, so ready alone marks its handshake.
    assign seq_hs = (state_q != IDLE) && resp_i.ready;

    plic_seq_addr_gen #(
        .N_SOURCE   (N_SOURCE),
        .N_TARGET   (N_TARGET),
        .MAX_PRIO   (MAX_PRIO),
        .DEF_PRIO   (DEF_PRIO),
        .DEF_THRESH (DEF_THRESH),
        .DEF_IE     (DEF_IE),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .state_i      (state_q),
        .advance_i    (seq_hs),
        .addr_o       (gen_addr),
        .wdata_o      (gen_wdata),
        .phase_last_o (phase_last),
        .last_o       (seq_last)
    );

    // Sequence FSM with registered busy/done/err; waits for an in-flight host transfer before taking the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= AUTO_START;
            busy_q    <= AUTO_START;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !busy_q) begin
                        pending_q <= 1'b1;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end
                    if (pending_q && (!req_i.valid || resp_i.ready)) begin
                        state_q   <= PRIO;
                        pending_q <= 1'b0;
                    end
                end
                PRIO: if (seq_hs && phase_last) state_q <= IE;
                IE:   if (seq_hs && phase_last) state_q <= THR;
                THR: begin
                    if (seq_hs && seq_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (seq_hs && resp_i.error) err_q <= 1'b1;
        end
    end

    // Bus ownership: host straight through in IDLE, sequencer writes otherwise with the host held off.
    always_comb begin
        req_o  = req_i;
        resp_o = resp_i;
        if (state_q != IDLE) begin
            req_o.addr  = gen_addr;
            req_o.write = 1'b1;
            req_o.wdata = gen_wdata;
            req_o.wstrb = 4'hF;
            req_o.valid = 1'b1;
            resp_o      = '0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_plic_init_sequencer.sv
module tb_plic_init_sequencer;

    logic clk;
    logic rst_n;
    logic start, start0;
    logic busy, done, err;
    logic busy0, done0, err0;

    reg_intf::reg_intf_req_a32_d32 host_req, plic_req, host0_req, plic0_req;
    reg_intf::reg_intf_resp_d32    host_resp, plic_resp, host0_resp, plic0_resp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr [12];
    logic [31:0] exp_data [12];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];

    int          done_cnt = 0;
    int          w0_cnt = 0;
    logic [31:0] w0_first = '0;

    int   rdy_mode = 0;
    logic rdy_man = 1'b0;
    logic err_en = 1'b0;
    int   stall_left = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    plic_init_sequencer #(
        .N_SOURCE(8), .N_TARGET(2), .MAX_PRIO(7), .DEF_PRIO(3), .DEF_THRESH(1),
        .DEF_IE(1'b1), .BASE_ADDR(32'h0), .AUTO_START(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
        .req_i(host_req), .resp_o(host_resp), .req_o(plic_req), .resp_i(plic_resp)
    );

    plic_init_sequencer #(
        .N_SOURCE(8), .N_TARGET(2), .MAX_PRIO(7), .DEF_PRIO(3), .DEF_THRESH(1),
        .DEF_IE(1'b1), .BASE_ADDR(32'h0), .AUTO_START(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0), .err_o(err0),
        .req_i(host0_req), .resp_o(host0_resp), .req_o(plic0_req), .resp_i(plic0_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // PLIC model: ready pattern and error injection, driven 2 time units after the edge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: plic_resp.ready = 1'b1;
            1: begin
                if (stall_left == 0) begin
                    plic_resp.ready = 1'b1;
                    stall_left = $urandom_range(0, 5);
                end else begin
                    plic_resp.ready = 1'b0;
                    stall_left--;
                end
            end
            default: plic_resp.ready = rdy_man;
        endcase
        plic_resp.error = err_en && (wq_addr.size() == 4);
    end

    // Record every accepted sequencer write; count done pulses; track the AUTO_START=0 instance.
    always @(negedge clk) begin
        if (rst_n && plic_req.valid && plic_req.write && plic_resp.ready) begin
            wq_addr.push_back(plic_req.addr);
            wq_data.push_back(plic_req.wdata);
        end
        if (rst_n && done) done_cnt++;
        if (rst_n && plic0_req.valid && plic0_req.write && plic0_resp.ready) begin
            if (w0_cnt == 0) w0_first = plic0_req.addr;
            w0_cnt++;
        end
    end

    // A stalled write must keep its address and data until accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && plic_req.valid && plic_req.write) begin
                chk("hold_addr", plic_req.addr, prev_addr);
                chk("hold_wdata", plic_req.wdata, prev_data);
            end
            prev_stall = plic_req.valid && plic_req.write && !plic_resp.ready;
            prev_addr  = plic_req.addr;
            prev_data  = plic_req.wdata;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        #1;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'd12);
        for (int i = 0; i < 12 && i < wq_addr.size(); i++) begin
            chk($sformatf("%s_w%0d_addr", tag, i), wq_addr[i], exp_addr[i]);
            chk($sformatf("%s_w%0d_data", tag, i), wq_data[i], exp_data[i]);
        end
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        int bad;
        int n;

        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = 32'(4 * (i + 1));
            exp_data[i] = 32'd3;
        end
        exp_addr[8]  = 32'h0000_2000; exp_data[8]  = 32'h0000_01FE;
        exp_addr[9]  = 32'h0000_2080; exp_data[9]  = 32'h0000_01FE;
        exp_addr[10] = 32'h0020_0000; exp_data[10] = 32'd1;
        exp_addr[11] = 32'h0020_1000; exp_data[11] = 32'd1;

        rst_n = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        host_req = '0;
        host0_req = '0;
        plic_resp = '0;
        plic0_resp = '0;
        plic0_resp.ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(plic_req.valid), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);

        // 1: auto start, ready tied high
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done("t1");
        repeat (5) @(negedge clk);
        #1;
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);
        check_writes("t1");

        // 2: random ready stalls
        rdy_mode = 1;
        pulse_start();
        wait_done("t2");
        check_writes("t2");
        rdy_mode = 0;

        // 3: host read in flight when start arrives
        rdy_mode = 2;
        rdy_man = 1'b0;
        @(posedge clk); #1;
        host_req.valid = 1'b1;
        host_req.write = 1'b0;
        host_req.addr  = 32'h1234;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_pass_addr", plic_req.addr, 32'h1234);
        chk("t3_host_wait", 32'(host_resp.ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rdy_man = 1'b1;
        @(negedge clk);
        chk("t3_host_hs", 32'(host_resp.ready), 32'd1);
        chk("t3_host_read", 32'(plic_req.write), 32'd0);
        @(posedge clk); #1;
        host_req.valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("t3_seq_valid", 32'(plic_req.valid), 32'd1);
        chk("t3_seq_write", 32'(plic_req.write), 32'd1);
        chk("t3_seq_addr", plic_req.addr, 32'h4);
        wait_done("t3");
        check_writes("t3");

        // 4: host request during a sequence
        pulse_start();
        @(posedge clk); #1;
        host_req.valid = 1'b1;
        host_req.write = 1'b0;
        host_req.addr  = 32'h40;
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done && host_resp.ready) bad++;
        end while (!done && n < 400);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_host_held", 32'(bad), 32'd0);
        chk("t4_host_served", 32'(host_resp.ready), 32'd1);
        chk("t4_pass_addr", plic_req.addr, 32'h40);
        @(posedge clk); #1 host_req.valid = 1'b0;
        check_writes("t4");

        // 5: error on the 5th write, then cleared by the next start
        err_en = 1'b1;
        pulse_start();
        wait_done("t5a");
        chk("t5_err_set", 32'(err), 32'd1);
        check_writes("t5a");
        err_en = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("t5_err_clr", 32'(err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        wait_done("t5b");
        chk("t5_err_stays_clr", 32'(err), 32'd0);
        check_writes("t5b");

        // 6: reset while enables are being written
        pulse_start();
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (wq_addr.size() < 9 && n < 400);
        chk("t6_in_ie", plic_req.addr, 32'h2000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(plic_req.valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd1);
        chk("t6_rst_busy0", 32'(busy0), 32'd0);
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done("t6");
        check_writes("t6");

        // AUTO_START=0 instance: idle until started
        chk("a0_no_writes", 32'(w0_cnt), 32'd0);
        chk("a0_idle", 32'(busy0), 32'd0);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 400);
        chk("a0_done", 32'(done0), 32'd1);
        #1;
        chk("a0_nwr", 32'(w0_cnt), 32'd12);
        chk("a0_first", w0_first, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
